// File: rtl/lzrw_pkg.sv
// Shared LZRW constants, FSM state type and length clamp helper.
package lzrw_pkg;

  localparam int unsigned LZRW_MAX_MATCH = 18;
  localparam int unsigned LZRW_MIN_MATCH = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } match_state_e;

  function automatic int unsigned clamp_len(input int unsigned avail,
                                            input int unsigned max_len);
    return (avail > max_len) ? max_len : avail;
  endfunction

endpackage

// File: rtl/lane_prefix_count.sv
// Counts leading equal bytes across a LANES-byte slice, limited to lim_i.
module lane_prefix_count #(
  parameter int unsigned LANES = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic [LANES*8-1:0] a_i,
  input  logic [LANES*8-1:0] b_i,
  input  logic [CNT_W-1:0]   lim_i,
  output logic [CNT_W-1:0]   k_o
);

  logic run_c;

  // Leading-equal scan; the first mismatch or the limit stops counting.
  always_comb begin
    k_o   = '0;
    run_c = 1'b1;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (run_c && (CNT_W'(i) < lim_i) && (a_i[i*8 +: 8] == b_i[i*8 +: 8])) begin
        k_o = CNT_W'(i + 1);
      end else begin
        run_c = 1'b0;
      end
    end
  end

endmodule

// File: rtl/match_length_engine.sv
// Multi-cycle LZRW match-length comparator: LANES bytes per cycle, early
// exit on mismatch, length capped at the bytes remaining in the input.
// Optional saturating statistics counters under `define MATCH_STATS_EN.
module match_length_engine
  import lzrw_pkg::*;
#(
  parameter int unsigned MAX_MATCH = LZRW_MAX_MATCH,
  parameter int unsigned MIN_MATCH = LZRW_MIN_MATCH,
  parameter int unsigned LANES     = 4,
  parameter int unsigned LEN_W     = $clog2(MAX_MATCH + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   cand_hit,
  input  logic [MAX_MATCH*8-1:0] cur_bytes,
  input  logic [MAX_MATCH*8-1:0] ref_bytes,
  input  logic [LEN_W+7:0]       avail_len,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LEN_W-1:0]       match_len,
  output logic                   match_ok,
  output logic                   busy,
  output logic [31:0]            stat_cmp,
  output logic [31:0]            stat_hit
);

  localparam logic [LEN_W-1:0] LANES_L = LEN_W'(LANES);
  localparam logic [LEN_W-1:0] MIN_L   = LEN_W'(MIN_MATCH);

  match_state_e           state_q, state_d;
  logic [MAX_MATCH*8-1:0] cur_q, cur_d, ref_q, ref_d;
  logic [LEN_W-1:0]       cap_q, cap_d, acc_q, acc_d, g_q, g_d;
  logic                   ok_q, ok_d;

  logic [LEN_W-1:0]       cap_in, remain, lim, k, acc_sum;
  logic [LANES*8-1:0]     cur_sl, ref_sl;
  logic                   accept;

  assign accept = in_valid && (state_q == IDLE);
  assign cap_in = LEN_W'(clamp_len(32'(avail_len), MAX_MATCH));

  // While comparing, acc always equals g*LANES, so cap-acc is the bytes left
  // for group g; this avoids a multiplier in the limit path.
  assign remain  = cap_q - acc_q;
  assign lim     = (remain < LANES_L) ? remain : LANES_L;
  assign acc_sum = acc_q + k;

  // Select group g; bytes past MAX_MATCH are forced unequal (00 vs FF).
  always_comb begin
    cur_sl = '0;
    ref_sl = '1;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (32'(g_q) * LANES + i < MAX_MATCH) begin
        cur_sl[i*8 +: 8] = cur_q[(32'(g_q) * LANES + i)*8 +: 8];
        ref_sl[i*8 +: 8] = ref_q[(32'(g_q) * LANES + i)*8 +: 8];
      end
    end
  end

  lane_prefix_count #(
    .LANES (LANES),
    .CNT_W (LEN_W)
  ) u_lane_prefix_count (
    .a_i   (cur_sl),
    .b_i   (ref_sl),
    .lim_i (lim),
    .k_o   (k)
  );

  // Next-state logic: accept, per-group compare, result handshake.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    ref_d   = ref_q;
    cap_d   = cap_q;
    acc_d   = acc_q;
    g_d     = g_q;
    ok_d    = ok_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          cur_d = cur_bytes;
          ref_d = ref_bytes;
          cap_d = cap_in;
          acc_d = '0;
          g_d   = '0;
          ok_d  = 1'b0;
          if (!cand_hit || (cap_in == '0)) begin
            state_d = DONE;
            ok_d    = (MIN_MATCH == 0);
          end else begin
            state_d = COMPARE;
          end
        end
      end
      COMPARE: begin
        acc_d = acc_sum;
        if ((k < lim) || (acc_sum == cap_q)) begin
          state_d = DONE;
          ok_d    = (acc_sum >= MIN_L);
        end else begin
          g_d = g_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      ref_q   <= '0;
      cap_q   <= '0;
      acc_q   <= '0;
      g_q     <= '0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      ref_q   <= ref_d;
      cap_q   <= cap_d;
      acc_q   <= acc_d;
      g_q     <= g_d;
      ok_q    <= ok_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign match_len = acc_q;
  assign match_ok  = ok_q;

`ifdef MATCH_STATS_EN
  logic [31:0] cmp_q, hit_q;

  // Saturating counters of accepted candidates and qualifying results.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmp_q <= '0;
      hit_q <= '0;
    end else begin
      if (accept && (cmp_q != '1)) cmp_q <= cmp_q + 32'd1;
      if ((state_q == DONE) && out_ready && ok_q && (hit_q != '1)) hit_q <= hit_q + 32'd1;
    end
  end

  assign stat_cmp = cmp_q;
  assign stat_hit = hit_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign stat_cmp      = '0;
  assign stat_hit      = '0;
`endif

endmodule

// File: tb/tb_match_length_engine.sv
// Self-checking bench for match_length_engine: directed cases plus random
// candidates checked against a byte-by-byte reference model.
module tb_match_length_engine;

  localparam int unsigned MAXM  = 18;
  localparam int unsigned MINM  = 3;
  localparam int unsigned LANES = 4;
  localparam int unsigned LEN_W = $clog2(MAXM + 1);

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              cand_hit = 1'b0;
  logic [MAXM*8-1:0] cur_bytes = '0;
  logic [MAXM*8-1:0] ref_bytes = '0;
  logic [LEN_W+7:0]  avail_len = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [LEN_W-1:0]  match_len;
  logic              match_ok;
  logic              busy;
  logic [31:0]       stat_cmp, stat_hit;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cmp  = 0;
  int exp_hit  = 0;

  always #5 clk = ~clk;

  match_length_engine #(
    .MAX_MATCH (MAXM),
    .MIN_MATCH (MINM),
    .LANES     (LANES)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cand_hit  (cand_hit),
    .cur_bytes (cur_bytes),
    .ref_bytes (ref_bytes),
    .avail_len (avail_len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .match_len (match_len),
    .match_ok  (match_ok),
    .busy      (busy),
    .stat_cmp  (stat_cmp),
    .stat_hit  (stat_hit)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_stats();
`ifdef MATCH_STATS_EN
    check_eq("stat_cmp", stat_cmp, 32'(exp_cmp));
    check_eq("stat_hit", stat_hit, 32'(exp_hit));
`else
    check_eq("stat_cmp_tied", stat_cmp, 32'd0);
    check_eq("stat_hit_tied", stat_hit, 32'd0);
`endif
  endtask

  // Reference: walk bytes until mismatch or cap; latency from group count.
  function automatic void model(input logic hit, input int unsigned avail,
                                input logic [MAXM*8-1:0] c, input logic [MAXM*8-1:0] r,
                                output int len, output int lat);
    int unsigned cap;
    cap = (avail > MAXM) ? MAXM : avail;
    len = 0;
    if (hit) begin
      while ((len < int'(cap)) && (c[len*8 +: 8] == r[len*8 +: 8])) len++;
    end
    if (!hit || cap == 0)      lat = 1;
    else if (len == int'(cap)) lat = 1 + int'((cap + LANES - 1) / LANES);
    else                       lat = 1 + len / int'(LANES) + 1;
  endfunction

  function automatic logic [MAXM*8-1:0] rand_bytes();
    logic [MAXM*8-1:0] v;
    for (int i = 0; i < int'(MAXM); i++) v[i*8 +: 8] = 8'($urandom);
    return v;
  endfunction

  // Offer one candidate, check latency/result, hold the result for `hold`
  // cycles while a competing candidate is offered, then complete handshake.
  task automatic do_cand(input logic hit, input logic [LEN_W+7:0] avail,
                         input logic [MAXM*8-1:0] c, input logic [MAXM*8-1:0] r,
                         input int hold);
    int exp_len, exp_lat, cyc;
    model(hit, int'(avail), c, r, exp_len, exp_lat);
    @(negedge clk);
    check_eq("in_ready_idle", in_ready, 1);
    cand_hit = hit; avail_len = avail; cur_bytes = c; ref_bytes = r; in_valid = 1'b1;
    @(posedge clk); #1;
    exp_cmp++;
    in_valid  = 1'b0;
    cur_bytes = rand_bytes();
    ref_bytes = rand_bytes();
    avail_len = (LEN_W+8)'($urandom);
    cand_hit  = ~hit;
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (out_valid) break;
    end
    check_eq("latency", cyc, exp_lat);
    check_eq("match_len", match_len, exp_len);
    check_eq("match_ok", match_ok, (exp_len >= int'(MINM)) ? 1 : 0);
    in_valid = (hold > 0);
    cand_hit = 1'b1;
    avail_len = (LEN_W+8)'(MAXM);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_len", match_len, exp_len);
      check_eq("hold_ok", match_ok, (exp_len >= int'(MINM)) ? 1 : 0);
      check_eq("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    if (exp_len >= int'(MINM)) exp_hit++;
    check_eq("post_valid", out_valid, 0);
    check_eq("post_in_ready", in_ready, 1);
    check_stats();
  endtask

  initial begin
    logic [MAXM*8-1:0] a, b;
    int pos;

    // Reset values
    #3;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_match_len", match_len, 0);
    check_eq("rst_match_ok", match_ok, 0);
    check_eq("rst_busy", busy, 0);
    check_stats();
    #20;
    @(negedge clk);
    reset_n = 1'b1;

    // 1: full match, clamped avail
    a = rand_bytes();
    do_cand(1'b1, 13'd40, a, a, 0);
    // 2: mismatch at index 5
    b = a; b[5*8 +: 8] = ~a[5*8 +: 8];
    do_cand(1'b1, 13'd40, a, b, 0);
    // 3: no hash hit
    do_cand(1'b0, 13'd40, a, a, 0);
    // 4: short input tail, and empty input
    do_cand(1'b1, 13'd2, a, a, 0);
    do_cand(1'b1, 13'd0, a, a, 0);
    // exact group boundaries, large avail clamp
    b = a; b[4*8 +: 8] = ~a[4*8 +: 8];
    do_cand(1'b1, 13'd18, a, b, 1);
    do_cand(1'b1, 13'd16, a, a, 0);
    do_cand(1'b1, 13'h1FFF, a, a, 0);
    // 5: result held with a second candidate offered
    do_cand(1'b1, 13'd40, a, a, 3);
    do_cand(1'b1, 13'd40, a, b, 0);

    // Random candidates
    for (int n = 0; n < 60; n++) begin
      a = rand_bytes();
      b = a;
      pos = $urandom_range(0, 22);
      if (pos < int'(MAXM)) b[pos*8 +: 8] = a[pos*8 +: 8] ^ 8'($urandom_range(1, 255));
      do_cand(($urandom_range(0, 7) != 0), ($urandom_range(0, 5) == 0) ? 13'($urandom) : 13'($urandom_range(0, 24)),
              a, b, $urandom_range(0, 3));
    end

    // 6: reset during the second compare cycle of a full match
    @(negedge clk);
    a = rand_bytes();
    cand_hit = 1'b1; avail_len = 13'd40; cur_bytes = a; ref_bytes = a; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    exp_cmp = 0; exp_hit = 0;
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_match_len", match_len, 0);
    check_eq("midrst_busy", busy, 0);
    check_stats();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("midrst_in_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("no_stale_result", out_valid, 0);
    end
    check_stats();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/match_length_engine.md
Name: match_length_engine

Overview:
Parametrised, multi-cycle successor to the LZRW1 match comparator. Accepts one candidate (current bytes, history bytes at the hash-table offset, and the control bit) over a valid/ready handshake. Counts leading equal bytes LANES per cycle, stops early at the first mismatch, and caps the count at the bytes remaining in the input. Sits between the hash-table lookup and the copy/literal encoder.

Parameters:
MAX_MATCH, 18, maximum match length in bytes (LZRW1: 18)
MIN_MATCH, 3, minimum length that qualifies as a copy item
LANES, 4, bytes compared per cycle (1..MAX_MATCH)
LEN_W, $clog2(MAX_MATCH+1), width of length fields (derived, do not override)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
in_valid  in  1  candidate present
in_ready  out  1  engine can accept a candidate
cand_hit  in  1  control bit from the hash table (offset valid)
cur_bytes  in  MAX_MATCH*8  current input bytes; byte 0 in bits [7:0]
ref_bytes  in  MAX_MATCH*8  history bytes at the offset, same packing
avail_len  in  LEN_W+8  bytes remaining in the input stream
out_valid  out  1  result present
out_ready  in  1  consumer takes the result
match_len  out  LEN_W  leading equal byte count
match_ok  out  1  match_len >= MIN_MATCH
busy  out  1  state != IDLE
stat_cmp  out  32  candidates accepted (see Optional Feature)
stat_hit  out  32  results with match_ok=1 (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, match_len=0, match_ok=0, busy=0, stat_*=0, all internal registers zeroed.
- States: IDLE, COMPARE, DONE.
- in_ready = (state==IDLE). It is combinational from state only and never depends on in_valid.
- Accept happens when in_valid && in_ready. On accept:
  - Register cur_bytes, ref_bytes and cap = min(avail_len, MAX_MATCH).
  - Clear the accumulator and set group g=0.
  - If !cand_hit or cap==0: go to DONE with len=0. out_valid is asserted 1 cycle after accept.
  - Otherwise go to COMPARE.
- COMPARE, one cycle per group:
  - Group g covers bytes g*LANES .. g*LANES+LANES-1.
  - lim = min(LANES, cap - g*LANES). k = count of leading equal bytes within the group, limited to lim.
  - Byte indices >= MAX_MATCH are treated as unequal, so the last group may be partial.
  - acc += k.
  - If k < lim or acc+k == cap: go to DONE. Otherwise g++.
- DONE:
  - out_valid=1. match_len=acc and match_ok are registered.
  - Both are held stable while out_valid && !out_ready.
  - On out_ready: out_valid=0 and state goes to IDLE. The next accept can happen no earlier than the following cycle.
- Latency from accept to out_valid: 1 + number of groups examined. Worst case is 1 + ceil(MAX_MATCH/LANES).
- Width rules:
  - acc is LEN_W bits and never exceeds cap.
  - The cap comparison uses the full avail_len width before narrowing, so avail_len > MAX_MATCH clamps to MAX_MATCH.
- Input operands are sampled only at accept. Changes on cur_bytes/ref_bytes afterwards have no effect.
- Reset mid-operation (reset_n low in any state): immediate return to reset values. A pending result is discarded and is not reported after release.
- in_valid while busy: ignored. The upstream holds the candidate until in_ready.

Optional Feature:
MATCH_STATS_EN
- Defined: stat_cmp increments on every accept. stat_hit increments on every DONE->IDLE handshake with match_ok=1. Both are 32-bit saturating counters, reset to 0.
- Undefined: stat_cmp and stat_hit are tied to 0 and no counter flops are synthesised. Ports are present in both builds.

Decomposition:
- Package lzrw_pkg holds:
  - LZRW_MAX_MATCH=18, LZRW_MIN_MATCH=3.
  - typedef enum logic [1:0] {IDLE, COMPARE, DONE} match_state_e.
  - Helper function clamp_len(avail, max).
- One combinational sub-module, lane_prefix_count (parameter LANES): inputs are two LANES-byte slices and lim; output is the leading-equal count k.

Test Plan:
1. MAX_MATCH=18, LANES=4, cand_hit=1, identical 18 bytes, avail_len=40 -> match_len=18, match_ok=1, out_valid at accept+6.
2. Bytes equal except index 5, avail_len=40 -> match_len=5, match_ok=1, out_valid at accept+3 (2 groups).
3. cand_hit=0, identical data -> match_len=0, match_ok=0, out_valid at accept+1, COMPARE never entered.
4. Identical data, avail_len=2 -> match_len=2, match_ok=0. With avail_len=0 -> match_len=0 at accept+1.
5. Result pending, out_ready held low 3 cycles -> match_len/match_ok/out_valid stable, in_ready=0, second in_valid ignored. Accepted the cycle after out_ready.
6. reset_n asserted in the 2nd COMPARE cycle of case 1 -> out_valid=0, match_len=0, busy=0 immediately; in_ready=1 after release; no stale result appears. With MATCH_STATS_EN, stat_cmp=0.
